hilo_unit: RTL and testbench
============================

# hilo_unit

Execute-stage multiply/divide unit owning the architectural HI/LO registers. It consumes the ALU operation code and both operands produced by the decode-stage controller, one stage downstream. It performs MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO/MFHI/MFLO/MUL, iterating the divide over many cycles. It tells the pipeline when a dependent instruction must stall in EX.

## Interface
- No parameters; data width is fixed at 32.
- `clock`  in  1  — the only clock; all state updates on its rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `op_valid`  in  1  — an instruction occupies EX this cycle.
- `alu_op`  in  5  — ALUOp code from decode; encodings come from the shared package.
- `rs_val`  in  32  — forwarded operand A, the dividend or multiplicand.
- `rt_val`  in  32  — forwarded operand B.
- `flush`  in  1  — the EX instruction is being killed this cycle.
- `stall`  out  1  — EX must hold; combinational.
- `busy`  out  1  — a multi-cycle operation is in flight (state ≠ IDLE).
- `result`  out  32  — GPR write value for MFHI, MFLO and MUL; combinational.
- `hi_q`, `lo_q`  out  32 each  — current HI and LO, for debug and exception save.

## Operation
- **Accept:** an op is accepted when `op_valid & ~flush & ~stall` and `alu_op` is a HI/LO-class op. Any other `alu_op` is ignored.
- **Stall:** `stall = op_valid & hilo_class(alu_op) & busy`. Non-HI/LO instructions never stall.
- **States:**
  - IDLE
  - MACC: product registered, awaiting writeback.
  - DIV: 32 iterations, counter 0..31.
  - DFIX: sign correction and writeback.
- **IDLE transitions:**
  - MULT/MULTU/MADD*/MSUB* → MACC.
  - DIV/DIVU → DIV.
  - MTHI/MTLO write HI/LO at the acceptance edge and stay in IDLE.
- **MACC → IDLE:**
  - MULT/MULTU: {HI,LO} = product.
  - MADD/MADDU: {HI,LO} = {HI,LO} + product.
  - MSUB/MSUBU: {HI,LO} = {HI,LO} − product.
  - All arithmetic is 64-bit modulo 2^64.
  - Signed ops sign-extend the operands to 33 bits; unsigned ops zero-extend.
- **DIV:**
  - Radix-2 restoring iteration on operand magnitudes.
  - At counter 31 → DFIX.
  - DFIX applies signs: quotient is negative iff the operand signs differ; remainder takes the dividend's sign. It writes LO = quotient, HI = remainder, then → IDLE.
- **Divide by zero:** LO = 0xFFFF_FFFF, HI = rs_val, for both signed and unsigned; no exception.
- **Signed overflow:** 0x8000_0000 / −1 gives LO = 0x8000_0000, HI = 0.
- **`result`:**
  - MFHI returns `hi_q`.
  - MFLO returns `lo_q`.
  - MUL returns the low 32 bits of the signed product, computed combinationally; HI/LO are unchanged.
  - For all other ops `result` is 0.
- **Flush:** `flush` only gates acceptance. An accepted op always completes; it is architecturally older than any later exception.
- **Operand capture:** operands are captured at acceptance; later changes to `rs_val`/`rt_val` have no effect.

## Timing
- **Reset:** state = IDLE; `hi_q` = `lo_q` = 0; `busy` = 0.
  - `stall` = 0 and `result` = 0 whenever `op_valid` = 0.
  - Reset asserted mid-divide aborts it and applies the same values.
- **MTHI/MTLO** accepted in cycle N: new value visible on `hi_q`/`lo_q` from N+1.
- **Multiply-class** accepted in N: `busy` high in N+1, HI/LO updated at the end of N+1, MFHI/MFLO stall in N+1 and read the new value in N+2.
- **Divide** accepted in N: `busy` high for N+1..N+33 (32 DIV cycles plus DFIX), HI/LO valid from N+34.
- **Back-to-back ops:** a second HI/LO op presented while busy stalls and is accepted in the first IDLE cycle. MUL also stalls while busy.
- **Same-cycle MTHI and completion:** impossible, because MTHI stalls while busy.

## Configuration
- **`HILO_MADD_EN` defined:** MADD/MADDU/MSUB/MSUBU are implemented as above.
- **`HILO_MADD_EN` undefined:**
  - Those four codes are not HI/LO-class: never accepted, never stall, HI/LO unchanged.
  - The accumulate adder is removed.

## Structure
- **Shared package:**
  - The ALUOp encodings, reused from decode.
  - A `hilo_state_t` enum.
  - Constant `DIV_ITER` = 32.
- **Sub-module `hilo_divider`:**
  - Holds the magnitude remainder/quotient registers and the iteration counter.
  - Has a start/done handshake: `start` pulses for one cycle; `done` is high during the final iteration cycle.
  - Its outputs are the unsigned quotient and remainder.
- **Top level:** the multiplier, accumulate, sign fix and FSM stay in `hilo_unit`.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-divide → `busy` = 0, `hi_q` = `lo_q` = 0, next DIV restarts cleanly.
- **MULT:** MULT 0xFFFF_FFFF × 2 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFE. MULTU of the same operands → HI = 1, LO = 0xFFFF_FFFE. MFLO in N+1 stalls, in N+2 reads the value.
- **DIV:**
  - DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF; `busy` high exactly 33 cycles.
  - DIVU 7 / 0 → LO = 0xFFFF_FFFF, HI = 7.
- **MADD / MSUB:** HI:LO = 0:0xFFFF_FFFF, then MADDU 1 × 1 → HI = 1, LO = 0. MSUB 1 × 1 from 0:0 → HI = LO = 0xFFFF_FFFF. With the macro undefined, MADD leaves HI/LO unchanged and never stalls.
- **Flush:** DIV presented with `flush` = 1 → not accepted, `busy` stays 0. `flush` asserted during a busy DIV → DIV still completes.
- **MTHI/MUL:** MTHI 0x1234 then MFHI next cycle → `result` = 0x1234. MUL 3 × −4 → `result` = 0xFFFF_FFF4, HI/LO unchanged.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALUOp encodings, FSM states, divide length.
// HILO_MADD_EN adds MADD/MADDU/MSUB/MSUBU to the HI/LO instruction class.
package hilo_pkg;

    localparam int DIV_ITER = 32;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_AND   = 5'd3;
    localparam logic [4:0] ALU_OR    = 5'd4;
    localparam logic [4:0] ALU_MULT  = 5'd8;
    localparam logic [4:0] ALU_MULTU = 5'd9;
    localparam logic [4:0] ALU_DIV   = 5'd10;
    localparam logic [4:0] ALU_DIVU  = 5'd11;
    localparam logic [4:0] ALU_MADD  = 5'd12;
    localparam logic [4:0] ALU_MADDU = 5'd13;
    localparam logic [4:0] ALU_MSUB  = 5'd14;
    localparam logic [4:0] ALU_MSUBU = 5'd15;
    localparam logic [4:0] ALU_MTHI  = 5'd16;
    localparam logic [4:0] ALU_MTLO  = 5'd17;
    localparam logic [4:0] ALU_MFHI  = 5'd18;
    localparam logic [4:0] ALU_MFLO  = 5'd19;
    localparam logic [4:0] ALU_MUL   = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MACC,
        ST_DIV,
        ST_DFIX
    } hilo_state_t;

    // Ops that touch HI/LO or the multiplier, and therefore must wait while the unit is busy.
    function automatic logic hilo_class(input logic [4:0] op);
        logic isClass;
        case (op)
            ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
            ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO, ALU_MUL: isClass = 1'b1;
`ifdef HILO_MADD_EN
            ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU:      isClass = 1'b1;
`endif
            default:                                       isClass = 1'b0;
        endcase
        return isClass;
    endfunction

endpackage

// File: rtl/hilo_divider.sv
// Radix-2 restoring divider on 32-bit magnitudes; one quotient bit per cycle after a start pulse.
// done_o is high during the last iteration; results are stable on the following cycle.
module hilo_divider
    import hilo_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dsr_q};
        if (start_i) begin
            rem_d    = 32'd0;
            quo_d    = dividend_i;
            dsr_d    = divisor_i;
            cnt_d    = 5'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            // A clear borrow bit means the shifted remainder covers the divisor.
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITER - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dsr_q    <= 32'd0;
            cnt_q    <= 5'd0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done_o      = active_q && (cnt_q == 5'(DIV_ITER - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage multiply/divide unit owning HI/LO, with pipeline stall generation.
// Define HILO_MADD_EN to include the MADD/MADDU/MSUB/MSUBU accumulate path.
module hilo_unit
    import hilo_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [4:0]  alu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    hilo_state_t state_q, state_d;
    logic [31:0] hi_d, lo_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] dvd_q, dvd_d;
    logic        dvsZero_q, dvsZero_d;
    logic        qNeg_q, qNeg_d;
    logic        rNeg_q, rNeg_d;
`ifdef HILO_MADD_EN
    logic        accAdd_q, accAdd_d;
    logic        accSub_q, accSub_d;
`endif

    logic        isClass, accept, mulSigned, divSigned, divStart, divDone;
    logic signed [63:0] mulA, mulB;
    logic [63:0] product;
    logic [31:0] absA, absB, divQuo, divRem;

    assign isClass  = hilo_class(alu_op);
    assign busy     = (state_q != ST_IDLE);
    assign stall    = op_valid & isClass & busy;
    assign accept   = op_valid & ~flush & ~stall & isClass;

    // One shared multiplier: 33-bit sign/zero extension, low 64 bits of the product kept.
    assign mulSigned = (alu_op == ALU_MULT) || (alu_op == ALU_MUL)
                    || (alu_op == ALU_MADD) || (alu_op == ALU_MSUB);
    assign mulA      = {{32{mulSigned & rs_val[31]}}, rs_val};
    assign mulB      = {{32{mulSigned & rt_val[31]}}, rt_val};
    assign product   = mulA * mulB;

    assign divSigned = (alu_op == ALU_DIV);
    assign absA      = (divSigned && rs_val[31]) ? -rs_val : rs_val;
    assign absB      = (divSigned && rt_val[31]) ? -rt_val : rt_val;
    assign divStart  = accept && ((alu_op == ALU_DIV) || (alu_op == ALU_DIVU));

    hilo_divider u_divider (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_i     (divStart),
        .dividend_i  (absA),
        .divisor_i   (absB),
        .done_o      (divDone),
        .quotient_o  (divQuo),
        .remainder_o (divRem)
    );

    always_comb begin
        result = 32'd0;
        if (op_valid) begin
            case (alu_op)
                ALU_MFHI: result = hi_q;
                ALU_MFLO: result = lo_q;
                ALU_MUL:  result = product[31:0];
                default:  result = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_d    = prod_q;
        dvd_d     = dvd_q;
        dvsZero_d = dvsZero_q;
        qNeg_d    = qNeg_q;
        rNeg_d    = rNeg_q;
`ifdef HILO_MADD_EN
        accAdd_d  = accAdd_q;
        accSub_d  = accSub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (alu_op)
                        ALU_MULT, ALU_MULTU: begin
                            prod_d  = product;
                            state_d = ST_MACC;
`ifdef HILO_MADD_EN
                            accAdd_d = 1'b0;
                            accSub_d = 1'b0;
`endif
                        end
`ifdef HILO_MADD_EN
                        ALU_MADD, ALU_MADDU: begin
                            prod_d   = product;
                            accAdd_d = 1'b1;
                            accSub_d = 1'b0;
                            state_d  = ST_MACC;
                        end
                        ALU_MSUB, ALU_MSUBU: begin
                            prod_d   = product;
                            accAdd_d = 1'b0;
                            accSub_d = 1'b1;
                            state_d  = ST_MACC;
                        end
`endif
                        ALU_DIV, ALU_DIVU: begin
                            dvd_d     = rs_val;
                            dvsZero_d = (rt_val == 32'd0);
                            qNeg_d    = divSigned & (rs_val[31] ^ rt_val[31]);
                            rNeg_d    = divSigned & rs_val[31];
                            state_d   = ST_DIV;
                        end
                        ALU_MTHI: hi_d = rs_val;
                        ALU_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MACC: begin
                {hi_d, lo_d} = prod_q;
`ifdef HILO_MADD_EN
                if (accAdd_q) begin
                    {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                end else if (accSub_q) begin
                    {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
                end
`endif
                state_d = ST_IDLE;
            end
            ST_DIV: begin
                if (divDone) begin
                    state_d = ST_DFIX;
                end
            end
            ST_DFIX: begin
                // Divide by zero bypasses the magnitudes and returns a fixed pattern.
                if (dvsZero_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = dvd_q;
                end else begin
                    lo_d = qNeg_q ? -divQuo : divQuo;
                    hi_d = rNeg_q ? -divRem : divRem;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            prod_q    <= 64'd0;
            dvd_q     <= 32'd0;
            dvsZero_q <= 1'b0;
            qNeg_q    <= 1'b0;
            rNeg_q    <= 1'b0;
`ifdef HILO_MADD_EN
            accAdd_q  <= 1'b0;
            accSub_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            prod_q    <= prod_d;
            dvd_q     <= dvd_d;
            dvsZero_q <= dvsZero_d;
            qNeg_q    <= qNeg_d;
            rNeg_q    <= rNeg_d;
`ifdef HILO_MADD_EN
            accAdd_q  <= accAdd_d;
            accSub_q  <= accSub_d;
`endif
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit; expectations follow HILO_MADD_EN when it is defined.
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        op_valid;
    logic [4:0]  alu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int testsRun  = 0;
    int failCount = 0;
    int busyCount;

`ifdef HILO_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    hilo_unit dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .alu_op   (alu_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .result   (result),
        .hi_q     (hi_q),
        .lo_q     (lo_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl);
        op_valid = v;
        alu_op   = op;
        rs_val   = a;
        rt_val   = b;
        flush    = fl;
    endtask

    // Inputs change 2 time units after a rising edge; checks sample 1 unit later.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(1'b1, op, a, b, 1'b0);
        step();
        applyStimulus(1'b0, ALU_NOP, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        #1;
        while (busy && n < 100) begin
            step();
            #1;
            n++;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic checkHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        checkOutput({tag, "_hi"}, hi_q, expHi);
        checkOutput({tag, "_lo"}, lo_q, expLo);
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, ALU_NOP, 32'd0, 32'd0, 1'b0);
        step();
        step();
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkHiLo("reset", 32'd0, 32'd0);
        reset_n = 1'b1;
        step();

        issue(ALU_MTHI, 32'h0000_1234, 32'd0);
        applyStimulus(1'b1, ALU_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mfhi_after_mthi", result, 32'h0000_1234);
        checkOutput("mfhi_no_stall", {31'd0, stall}, 32'd0);
        step();
        issue(ALU_MTLO, 32'h0000_5678, 32'd0);
        #1;
        checkOutput("mtlo_lo", lo_q, 32'h0000_5678);

        applyStimulus(1'b1, ALU_MUL, 32'd3, 32'hFFFF_FFFC, 1'b0);
        #1;
        checkOutput("mul_result", result, 32'hFFFF_FFF4);
        step();
        applyStimulus(1'b0, ALU_NOP, 32'd0, 32'd0, 1'b0);
        #1;
        checkHiLo("mul_keeps", 32'h0000_1234, 32'h0000_5678);

        issue(ALU_MULT, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(1'b1, ALU_MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mult_busy_n1", {31'd0, busy}, 32'd1);
        checkOutput("mflo_stall_n1", {31'd0, stall}, 32'd1);
        step();
        #1;
        checkOutput("mflo_nostall_n2", {31'd0, stall}, 32'd0);
        checkOutput("mflo_result_n2", result, 32'hFFFF_FFFE);
        checkOutput("mult_hi", hi_q, 32'hFFFF_FFFF);
        step();
        applyStimulus(1'b0, ALU_NOP, 32'd0, 32'd0, 1'b0);

        issue(ALU_MULTU, 32'hFFFF_FFFF, 32'd2);
        waitIdle("multu_idle");
        checkHiLo("multu", 32'd1, 32'hFFFF_FFFE);

        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        busyCount = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!busy) break;
            busyCount++;
            step();
        end
        checkOutput("div_busy_cycles", busyCount, 32'd33);
        checkHiLo("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // MADD presented while a divide runs, then unrelated instructions flushed in EX.
        issue(ALU_DIVU, 32'd100, 32'd7);
        applyStimulus(1'b1, ALU_MADD, 32'd1, 32'd1, 1'b0);
        #1;
        checkOutput("madd_stall_busy", {31'd0, stall}, {31'd0, MADD_EN});
        applyStimulus(1'b1, ALU_ADD, 32'd5, 32'd6, 1'b1);
        #1;
        checkOutput("add_never_stalls", {31'd0, stall}, 32'd0);
        waitIdle("divu_flush_idle");
        applyStimulus(1'b0, ALU_NOP, 32'd0, 32'd0, 1'b0);
        checkHiLo("divu_100_7", 32'd2, 32'd14);

        issue(ALU_DIVU, 32'd7, 32'd0);
        waitIdle("divzero_idle");
        checkHiLo("divu_by_zero", 32'd7, 32'hFFFF_FFFF);

        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle("div_ovf_idle");
        checkHiLo("div_overflow", 32'd0, 32'h8000_0000);

        applyStimulus(1'b1, ALU_DIV, 32'd50, 32'd5, 1'b1);
        step();
        applyStimulus(1'b0, ALU_NOP, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("flushed_div_busy", {31'd0, busy}, 32'd0);
        checkHiLo("flushed_div", 32'd0, 32'h8000_0000);

        issue(ALU_MTHI, 32'd0, 32'd0);
        issue(ALU_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(ALU_MADDU, 32'd1, 32'd1);
        #1;
        checkOutput("maddu_busy", {31'd0, busy}, {31'd0, MADD_EN});
        waitIdle("maddu_idle");
        checkHiLo("maddu", MADD_EN ? 32'd1 : 32'd0, MADD_EN ? 32'd0 : 32'hFFFF_FFFF);

        issue(ALU_MTHI, 32'd0, 32'd0);
        issue(ALU_MTLO, 32'd0, 32'd0);
        issue(ALU_MSUB, 32'd1, 32'd1);
        waitIdle("msub_idle");
        checkHiLo("msub", MADD_EN ? 32'hFFFF_FFFF : 32'd0, MADD_EN ? 32'hFFFF_FFFF : 32'd0);

        issue(ALU_MTHI, 32'hAAAA_0001, 32'd0);
        issue(ALU_DIVU, 32'd7, 32'd2);
        step();
        step();
        reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_div_busy", {31'd0, busy}, 32'd0);
        checkHiLo("reset_mid_div", 32'd0, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        issue(ALU_DIV, 32'd20, 32'hFFFF_FFFD);
        waitIdle("div_after_reset_idle");
        checkHiLo("div_20_neg3", 32'd2, 32'hFFFF_FFFA);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
